sequence_checker: RTL

SEQUENCE_CHECKER -- requirements
Module: sequence_checker

---
 rtl/sequence_checker.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sequence_checker.sv
// Byte-stream sync checker: hunts for the 8-byte pattern, verifies it, then flywheels while locked.
// Optional match/error statistics counters are built in when SEQ_CHECK_STATS_EN is defined.
module sequence_checker #(
  parameter int unsigned LOCK_COUNT    = 2,
  parameter int unsigned UNLOCK_ERRORS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       match,
  output logic       error,
  output logic       locked,
  output logic [2:0] pos
`ifdef SEQ_CHECK_STATS_EN
  ,
  output logic [15:0] match_count,
  output logic [15:0] error_count
`endif
);

  localparam int unsigned POS_W = 3;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LOCK_C   = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] UNLOCK_C = CNT_W'(UNLOCK_ERRORS);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(7);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] streak_q, streak_d;
  logic             seq_ok_q, seq_ok_d;
  logic             match_q, match_d;
  logic             error_q, error_d;
  logic             locked_q, locked_d;

  logic             hit;
  logic             last;
  logic [CNT_W-1:0] good_inc;
  logic [CNT_W-1:0] streak_inc;
  logic [POS_W-1:0] fallback;

  function automatic logic [7:0] seq_byte(input logic [POS_W-1:0] idx);
    logic [7:0] b;
    unique case (idx)
      3'd0:    b = 8'hAF;
      3'd1:    b = 8'hBC;
      3'd2:    b = 8'hE2;
      3'd3:    b = 8'h78;
      3'd4:    b = 8'hFF;
      3'd5:    b = 8'hE2;
      3'd6:    b = 8'h0B;
      default: b = 8'h8D;
    endcase
    return b;
  endfunction

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      pos_q    <= '0;
      good_q   <= '0;
      streak_q <= '0;
      seq_ok_q <= 1'b0;
      match_q  <= 1'b0;
      error_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      good_q   <= good_d;
      streak_q <= streak_d;
      seq_ok_q <= seq_ok_d;
      match_q  <= match_d;
      error_q  <= error_d;
      locked_q <= locked_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    good_d   = good_q;
    streak_d = streak_q;
    seq_ok_d = seq_ok_q;
    match_d  = 1'b0;
    error_d  = 1'b0;

    hit        = (in_data == seq_byte(pos_q));
    last       = (pos_q == POS_LAST);
    good_inc   = (good_q == CNT_MAX) ? good_q : good_q + CNT_W'(1);
    streak_inc = (streak_q == CNT_MAX) ? streak_q : streak_q + CNT_W'(1);
    // AF appears only at index 0, so it is the sole restart point
    fallback   = (in_data == 8'hAF) ? POS_W'(1) : POS_W'(0);

    if (in_valid) begin
      unique case (state_q)
        HUNT, VERIFY: begin
          if (hit) begin
            if (last) begin
              match_d = 1'b1;
              pos_d   = '0;
              good_d  = good_inc;
              if (good_inc >= LOCK_C) begin
                state_d  = LOCKED;
                seq_ok_d = 1'b1;
                streak_d = '0;
              end else begin
                state_d = VERIFY;
              end
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end else begin
            state_d = HUNT;
            pos_d   = fallback;
            good_d  = '0;
          end
        end
        LOCKED: begin
          pos_d = pos_q + POS_W'(1);
          if (hit) begin
            streak_d = '0;
          end else begin
            error_d  = 1'b1;
            streak_d = streak_inc;
            seq_ok_d = 1'b0;
          end
          if (last) begin
            match_d  = seq_ok_q && hit;
            seq_ok_d = 1'b1;
          end
          if (!hit && (streak_inc >= UNLOCK_C)) begin
            state_d  = HUNT;
            pos_d    = '0;
            streak_d = '0;
            good_d   = '0;
            seq_ok_d = 1'b0;
          end
        end
        default: begin
          state_d = HUNT;
          pos_d   = '0;
          good_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  assign match  = match_q;
  assign error  = error_q;
  assign locked = locked_q;
  assign pos    = pos_q;

`ifdef SEQ_CHECK_STATS_EN
  localparam int unsigned STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [STAT_W-1:0] match_cnt_q, match_cnt_d;
  logic [STAT_W-1:0] error_cnt_q, error_cnt_d;

  // Saturating event counters track the pulses registered on the same edge
  always_comb begin
    match_cnt_d = match_cnt_q;
    error_cnt_d = error_cnt_q;
    if (match_d && (match_cnt_q != STAT_MAX)) match_cnt_d = match_cnt_q + STAT_W'(1);
    if (error_d && (error_cnt_q != STAT_MAX)) error_cnt_d = error_cnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt_q <= '0;
      error_cnt_q <= '0;
    end else begin
      match_cnt_q <= match_cnt_d;
      error_cnt_q <= error_cnt_d;
    end
  end

  assign match_count = match_cnt_q;
  assign error_count = error_cnt_q;
`endif

endmodule
